// File: rtl/accum_if.sv
// Handshake bundle for accum_unit: burst start, operand stream and result.
// master drives start/len/operands/out_ready; slave is the accumulator.
interface accum_if #(
    parameter int N     = 32,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/accum_unit.sv
// Signed burst accumulator with optional saturation; result valid 1 cycle after the last accept.
// Operands stall freely on in_valid; the result holds in DONE until out_ready.
module accum_unit #(
    parameter int N     = 32,
    parameter int LEN_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    accum_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    localparam logic [N-1:0] ACC_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] ACC_MIN = {1'b1, {(N-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic [N-1:0]     w_sum;
    logic             w_ovf;
    logic [N-1:0]     w_acc_nxt;

    assign w_accept = bus.in_valid && (r_state == S_ACCUM);
    assign w_sum    = r_acc + bus.in_data;
    assign w_ovf    = (r_acc[N-1] == bus.in_data[N-1]) && (w_sum[N-1] != r_acc[N-1]);

    // Clamp direction follows the pre-add sign, which equals the operand sign on overflow.
    always_comb begin
        w_acc_nxt = w_sum;
        if (SAT && w_ovf) begin
            w_acc_nxt = r_acc[N-1] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && (r_cnt == LEN_W'(1))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_ACCUM);
        bus.out_valid = (r_state == S_DONE);
        bus.busy      = (r_state != S_IDLE);
        bus.out_sum   = r_acc;
        bus.out_ovf   = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_cnt <= bus.len;
                        r_ovf <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt - LEN_W'(1);
                        r_ovf <= r_ovf | w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accum_unit.sv
// Directed bench for accum_unit: one saturating and one wrapping instance.
module tb_accum_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    accum_if #(.N(32), .LEN_W(8)) s_if ();
    accum_if #(.N(32), .LEN_W(8)) w_if ();

    accum_unit #(.N(32), .LEN_W(8), .SAT(1'b1)) u_sat (.clk(clk), .rst(rst), .bus(s_if.slave));
    accum_unit #(.N(32), .LEN_W(8), .SAT(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(w_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_start(input logic [7:0] l);
        s_if.start = 1'b1;
        s_if.len   = l;
        tick();
        s_if.start = 1'b0;
    endtask

    task automatic s_feed(input logic [31:0] d);
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        tick();
        s_if.in_valid = 1'b0;
    endtask

    task automatic s_ack();
        s_if.out_ready = 1'b1;
        tick();
        s_if.out_ready = 1'b0;
    endtask

    task automatic w_start(input logic [7:0] l);
        w_if.start = 1'b1;
        w_if.len   = l;
        tick();
        w_if.start = 1'b0;
    endtask

    task automatic w_feed(input logic [31:0] d);
        w_if.in_valid = 1'b1;
        w_if.in_data  = d;
        tick();
        w_if.in_valid = 1'b0;
    endtask

    task automatic w_ack();
        w_if.out_ready = 1'b1;
        tick();
        w_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.start = 1'b1;
        s_if.len   = 8'd3;
        tick();
        tick();
        s_if.start = 1'b0;
        rst = 1'b0;
        checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", s_if.busy); end
        checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", s_if.in_ready); end
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", s_if.out_valid); end
        checks++; if (s_if.out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", s_if.out_sum); end
        checks++; if (s_if.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", s_if.out_ovf); end
        checks++; if (w_if.busy !== 1'b0) begin errors++; $display("FAIL reset_wrap_busy: got %b want 0", w_if.busy); end
    endtask

    task automatic test_basic();
        s_start(8'd3);
        checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", s_if.in_ready); end
        checks++; if (s_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", s_if.busy); end
        s_if.in_valid = 1'b1;
        s_if.in_data  = 32'd5;
        tick();
        s_if.in_data  = 32'hFFFF_FFFE;
        tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", s_if.out_valid); end
        s_if.in_data  = 32'd10;
        tick();
        s_if.in_valid = 1'b0;
        checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", s_if.out_valid); end
        checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done: got %b want 0", s_if.in_ready); end
        checks++; if (s_if.out_sum !== 32'd13) begin errors++; $display("FAIL basic_sum: got %h want %h", s_if.out_sum, 32'd13); end
        checks++; if (s_if.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", s_if.out_ovf); end
        s_ack();
        checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", s_if.busy); end
    endtask

    task automatic test_saturate();
        s_start(8'd2);
        s_feed(32'h7FFF_FFF0);
        s_feed(32'h0000_0020);
        checks++; if (s_if.out_sum !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos_sum: got %h want 7fffffff", s_if.out_sum); end
        checks++; if (s_if.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b want 1", s_if.out_ovf); end
        s_ack();
        s_start(8'd1);
        s_feed(32'd1);
        checks++; if (s_if.out_sum !== 32'd1) begin errors++; $display("FAIL sat_next_sum: got %h want 1", s_if.out_sum); end
        checks++; if (s_if.out_ovf !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %b want 0", s_if.out_ovf); end
        s_ack();
        // clamp then keep accumulating from the clamped value
        s_start(8'd3);
        s_feed(32'h7FFF_FFF0);
        s_feed(32'h0000_0020);
        s_feed(32'hFFFF_FFF0);
        checks++; if (s_if.out_sum !== 32'h7FFF_FFEF) begin errors++; $display("FAIL sat_continue_sum: got %h want 7fffffef", s_if.out_sum); end
        checks++; if (s_if.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_continue_ovf: got %b want 1", s_if.out_ovf); end
        s_ack();
        s_start(8'd2);
        s_feed(32'h8000_0000);
        s_feed(32'hFFFF_FFFF);
        checks++; if (s_if.out_sum !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg_sum: got %h want 80000000", s_if.out_sum); end
        checks++; if (s_if.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf: got %b want 1", s_if.out_ovf); end
        s_ack();
    endtask

    task automatic test_wrap();
        w_start(8'd2);
        w_feed(32'h7FFF_FFF0);
        w_feed(32'h0000_0020);
        checks++; if (w_if.out_sum !== 32'h8000_0010) begin errors++; $display("FAIL wrap_pos_sum: got %h want 80000010", w_if.out_sum); end
        checks++; if (w_if.out_ovf !== 1'b1) begin errors++; $display("FAIL wrap_pos_ovf: got %b want 1", w_if.out_ovf); end
        w_ack();
        w_start(8'd2);
        w_feed(32'h8000_0000);
        checks++; if (w_if.out_ovf !== 1'b0) begin errors++; $display("FAIL wrap_mid_ovf: got %b want 0", w_if.out_ovf); end
        w_feed(32'hFFFF_FFFF);
        checks++; if (w_if.out_sum !== 32'h7FFF_FFFF) begin errors++; $display("FAIL wrap_neg_sum: got %h want 7fffffff", w_if.out_sum); end
        checks++; if (w_if.out_ovf !== 1'b1) begin errors++; $display("FAIL wrap_neg_ovf: got %b want 1", w_if.out_ovf); end
        w_ack();
    endtask

    task automatic test_backpressure();
        logic [31:0] ops [4];
        int          idx;
        int          cyc;
        ops[0] = 32'd1; ops[1] = 32'd2; ops[2] = 32'd3; ops[3] = 32'd4;
        idx = 0;
        cyc = 0;
        s_start(8'd4);
        while (idx < 4 && cyc < 200) begin
            s_if.in_valid = 1'($urandom_range(0, 1));
            s_if.in_data  = s_if.in_valid ? ops[idx] : 32'hDEAD_BEEF;
            s_if.start    = 1'($urandom_range(0, 1));
            s_if.len      = 8'd1;
            tick();
            if (s_if.in_valid) idx++;
            cyc++;
        end
        s_if.in_valid = 1'b0;
        s_if.start    = 1'b0;
        checks++; if (idx != 4) begin errors++; $display("FAIL bp_timeout: got %0d accepts want 4", idx); end
        for (int i = 0; i < 5; i++) begin
            s_if.start = 1'b1;
            s_if.len   = 8'd7;
            tick();
            checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid: got %b want 1", s_if.out_valid); end
            checks++; if (s_if.out_sum !== 32'd10) begin errors++; $display("FAIL bp_stall_sum: got %h want %h", s_if.out_sum, 32'd10); end
        end
        // start in the handshake cycle must not launch a burst
        s_if.out_ready = 1'b1;
        tick();
        s_if.out_ready = 1'b0;
        s_if.start     = 1'b0;
        checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL bp_hs_start: got %b want 0", s_if.busy); end
        tick();
        checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL bp_idle_hold: got %b want 0", s_if.busy); end
    endtask

    task automatic test_len_zero();
        s_start(8'd0);
        checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL len0_valid: got %b want 1", s_if.out_valid); end
        checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready: got %b want 0", s_if.in_ready); end
        checks++; if (s_if.out_sum !== 32'h0) begin errors++; $display("FAIL len0_sum: got %h want 0", s_if.out_sum); end
        checks++; if (s_if.out_ovf !== 1'b0) begin errors++; $display("FAIL len0_ovf: got %b want 0", s_if.out_ovf); end
        s_ack();
    endtask

    task automatic test_max_len();
        s_start(8'd255);
        s_if.in_valid = 1'b1;
        s_if.in_data  = 32'd2;
        for (int i = 0; i < 254; i++) tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL maxlen_early: got %b want 0", s_if.out_valid); end
        tick();
        s_if.in_valid = 1'b0;
        checks++; if (s_if.out_sum !== 32'd510) begin errors++; $display("FAIL maxlen_sum: got %h want %h", s_if.out_sum, 32'd510); end
        checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL maxlen_valid: got %b want 1", s_if.out_valid); end
        s_ack();
    endtask

    task automatic test_reset_mid();
        s_start(8'd4);
        s_feed(32'd5);
        s_feed(32'd6);
        rst = 1'b1;
        s_if.in_valid = 1'b1;
        s_if.in_data  = 32'd100;
        tick();
        rst = 1'b0;
        s_if.in_valid = 1'b0;
        checks++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", s_if.busy); end
        checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0", s_if.in_ready); end
        checks++; if (s_if.out_sum !== 32'h0) begin errors++; $display("FAIL rstmid_sum: got %h want 0", s_if.out_sum); end
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", s_if.out_valid); end
        s_start(8'd1);
        s_feed(32'd7);
        checks++; if (s_if.out_sum !== 32'd7) begin errors++; $display("FAIL rstmid_new_sum: got %h want 7", s_if.out_sum); end
        checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %b want 1", s_if.out_valid); end
        s_ack();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        s_if.start = 1'b0; s_if.len = '0; s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b0;
        w_if.start = 1'b0; w_if.len = '0; w_if.in_valid = 1'b0; w_if.in_data = '0; w_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_max_len();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
